// File: rtl/dma_transfer_ctrl.sv
// Single-channel word-copy DMA engine: range-checks a request, then moves words
// one read/write pair at a time while it owns the memory bus.
module dma_transfer_ctrl #(
  parameter int LAST_ADDR = 190,
  parameter int RSVD_ADDR = 191
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  src_addr,
  input  logic [7:0]  dst_addr,
  input  logic [7:0]  count,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [8:0]  mem_index,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} state_t;

  // The bookkeeping word must stay out of reach even if the parameters are mis-set.
  localparam int         LIMIT  = (LAST_ADDR < RSVD_ADDR) ? LAST_ADDR : RSVD_ADDR - 1;
  localparam logic [8:0] LIMIT9 = 9'(LIMIT);

  state_t      state_q, state_d;
  logic [7:0]  sp, dp, cnt;
  logic [31:0] data_q;
  logic        err_q;

  logic [8:0]  src_end, dst_end;
  logic        reject;

  // 9-bit end addresses so a range that wraps past 255 is seen as out of range.
  assign src_end = {1'b0, src_addr} + {1'b0, count} - 9'd1;
  assign dst_end = {1'b0, dst_addr} + {1'b0, count} - 9'd1;
  assign reject  = (count != 8'd0) && ((src_end > LIMIT9) || (dst_end > LIMIT9));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (count == 8'd0)
          state_d = FIN;
        else if (!reject)
          state_d = REQ;
      end
      REQ:  if (bus_grant) state_d = RD;
      RD:   state_d = bus_grant ? WR : REQ;
      WR: begin
        if (cnt == 8'd1)
          state_d = FIN;
        else
          state_d = bus_grant ? RD : REQ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sp      <= 8'd0;
      dp      <= 8'd0;
      cnt     <= 8'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && reject;
      if (state_q == IDLE && start) begin
        sp  <= src_addr;
        dp  <= dst_addr;
        cnt <= count;
      end
      if (state_q == RD)
        data_q <= mem_rdata;
      // The write always lands, so pointers advance even if the grant just dropped.
      if (state_q == WR) begin
        sp  <= sp + 8'd1;
        dp  <= dp + 8'd1;
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    bus_req   = (state_q == REQ) || (state_q == RD) || (state_q == WR);
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    error     = err_q;
    mem_index = 9'h000;
    mem_wr    = 1'b0;
    mem_wdata = 32'h0;
    if (state_q == RD) begin
      mem_index = {1'b1, sp};
    end else if (state_q == WR) begin
      mem_index = {1'b1, dp};
      mem_wr    = 1'b1;
      mem_wdata = data_q;
    end
  end

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Directed bench for dma_transfer_ctrl with a behavioural 256-word memory
// preloaded so that mem[i] = i + 1.
module tb_dma_transfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  src_addr, dst_addr, count;
  logic        bus_req, bus_grant;
  logic [8:0]  mem_index;
  logic        mem_wr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, done, error;

  logic [31:0] mem [0:255];
  logic        mem_init;
  int          wr_count;
  int          rsvd_hits;
  int          compares = 0;
  int          fails = 0;
  int          wr_snap;

  dma_transfer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .mem_index (mem_index),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_index[8] && !mem_wr) ? mem[mem_index[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i + 1);
      wr_count  <= 0;
      rsvd_hits <= 0;
    end else begin
      if (mem_index[8] && mem_wr) begin
        mem[mem_index[7:0]] <= mem_wdata;
        wr_count <= wr_count + 1;
      end
      if (mem_index[8] && mem_index[7:0] == 8'd191)
        rsvd_hits <= rsvd_hits + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},  32'(busy),      0);
    chk({tag, ".req"},   32'(bus_req),   0);
    chk({tag, ".index"}, 32'(mem_index), 0);
    chk({tag, ".wr"},    32'(mem_wr),    0);
    chk({tag, ".wdata"}, mem_wdata,      0);
    chk({tag, ".done"},  32'(done),      0);
    chk({tag, ".error"}, 32'(error),     0);
  endtask

  task automatic go(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    src_addr = s; dst_addr = d; count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bus_grant = 1'b0;
    src_addr = 8'd0; dst_addr = 8'd0; count = 8'd0;
    mem_init = 1'b1;
    #2;
    chk_quiet("reset");
    tick();
    mem_init = 1'b0;
    reset = 1'b0;

    // Three-word copy with grant held: REQ, 3 x (RD,WR), FIN.
    bus_grant = 1'b1;
    go(8'd0, 8'd100, 8'd3);
    chk("t1.req",   32'(bus_req), 1);
    chk("t1.busy",  32'(busy), 1);
    chk("t1.reqix", 32'(mem_index), 0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("t1.rdix", 32'(mem_index), 'h100 + w);
      chk("t1.rdwr", 32'(mem_wr), 0);
      tick();
      chk("t1.wrix", 32'(mem_index), 'h164 + w);
      chk("t1.wrwr", 32'(mem_wr), 1);
      chk("t1.wdat", mem_wdata, w + 1);
    end
    tick();
    chk("t1.done",  32'(done), 1);
    chk("t1.finrq", 32'(bus_req), 0);
    chk("t1.finbz", 32'(busy), 1);
    tick();
    chk("t1.done0", 32'(done), 0);
    chk("t1.idle",  32'(busy), 0);
    chk("t1.m100",  mem[100], 1);
    chk("t1.m101",  mem[101], 2);
    chk("t1.m102",  mem[102], 3);

    // Grant lost during the first read: back to REQ, the read repeats.
    go(8'd10, 8'd150, 8'd2);
    tick();
    chk("t2.rdix", 32'(mem_index), 'h10A);
    bus_grant = 1'b0;
    tick();
    chk("t2.back", 32'(bus_req), 1);
    chk("t2.noix", 32'(mem_index), 0);
    chk("t2.m150", mem[150], 151);
    tick();
    chk("t2.wait", 32'(mem_index), 0);
    bus_grant = 1'b1;
    tick();
    chk("t2.rd1",  32'(mem_index), 'h10A);
    tick();
    chk("t2.wr1",  32'(mem_index), 'h196);
    chk("t2.wd1",  mem_wdata, 11);
    tick();
    chk("t2.rd2",  32'(mem_index), 'h10B);
    tick();
    chk("t2.wr2",  32'(mem_index), 'h197);
    chk("t2.wd2",  mem_wdata, 12);
    tick();
    chk("t2.done", 32'(done), 1);
    tick();
    chk("t2.a150", mem[150], 11);
    chk("t2.a151", mem[151], 12);

    // Destination end 191 is past the last usable word.
    wr_snap = wr_count;
    go(8'd0, 8'd189, 8'd3);
    chk("t3.err",  32'(error), 1);
    chk("t3.req",  32'(bus_req), 0);
    chk("t3.busy", 32'(busy), 0);
    tick();
    chk("t3.err0", 32'(error), 0);
    chk("t3.req0", 32'(bus_req), 0);
    chk("t3.m189", mem[189], 190);
    chk("t3.m190", mem[190], 191);

    // 250+10-1 wraps in 8 bits but is 259 in 9 bits.
    go(8'd250, 8'd0, 8'd10);
    chk("t4.err",  32'(error), 1);
    chk("t4.ix",   32'(mem_index), 0);
    tick();
    chk("t4.err0", 32'(error), 0);
    chk("t4.busy", 32'(busy), 0);
    chk("t4.req",  32'(bus_req), 0);
    chk("t4.wrs",  32'(wr_count), 32'(wr_snap));

    // Zero-length request completes immediately without the bus.
    go(8'd5, 8'd5, 8'd0);
    chk("t5.done", 32'(done), 1);
    chk("t5.req",  32'(bus_req), 0);
    chk("t5.cs",   32'(mem_index[8]), 0);
    chk("t5.err",  32'(error), 0);
    tick();
    chk("t5.done0", 32'(done), 0);
    chk("t5.busy",  32'(busy), 0);

    // Reset during the write of word 2 of a five-word copy.
    go(8'd20, 8'd120, 8'd5);
    tick(); tick(); tick(); tick();
    chk("t6.inwr", 32'(mem_index), 'h179);
    chk("t6.wr",   32'(mem_wr), 1);
    reset = 1'b1;
    #1;
    chk_quiet("t6.rst");
    tick();
    chk("t6.rdone", 32'(done), 0);
    reset = 1'b0;
    tick();
    chk("t6.pdone", 32'(done), 0);
    chk("t6.m120",  mem[120], 21);
    chk("t6.m121",  mem[121], 122);
    go(8'd30, 8'd160, 8'd1);
    chk("t6.acc",  32'(bus_req), 1);
    tick();
    tick();
    chk("t6.wd",   mem_wdata, 31);
    tick();
    chk("t6.done", 32'(done), 1);
    tick();
    chk("t6.m160", mem[160], 31);
    chk("rsvd",    32'(rsvd_hits), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/dma_transfer_ctrl.md
DMA_TRANSFER_CTRL -- requirements
Module: dma_transfer_ctrl

Interface
REQ-001 The block SHALL have parameter LAST_ADDR, default 190, which is the highest usable memory word address.
REQ-002 The block SHALL have parameter RSVD_ADDR, default 191, which is the memory bookkeeping word; the block never accesses it.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: transfer request, sampled on a clk edge while idle.
REQ-006 The block SHALL have port src_addr, input, 8 bits: first source word address.
REQ-007 The block SHALL have port dst_addr, input, 8 bits: first destination word address.
REQ-008 The block SHALL have port count, input, 8 bits: number of words to copy.
REQ-009 The block SHALL have port bus_req, output, 1 bit: request for memory bus ownership.
REQ-010 The block SHALL have port bus_grant, input, 1 bit: bus ownership granted; the grant may drop at any cycle.
REQ-011 The block SHALL have port mem_index, output, 9 bits: bit 8 is memory chip select, bits [7:0] are the word address.
REQ-012 The block SHALL have port mem_wr, output, 1 bit: 1 means write, 0 means read.
REQ-013 The block SHALL have port mem_wdata, output, 32 bits: write data; the top level drives databus from it when mem_wr=1.
REQ-014 The block SHALL have port mem_rdata, input, 32 bits: databus value during reads.
REQ-015 The block SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-017 The block SHALL have port error, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, RD, WR and FIN, all registered, with outputs decoded from state.
REQ-019 In IDLE, when start=1, the block SHALL latch src_addr, dst_addr and count into the internal registers sp, dp and cnt.
REQ-020 A start SHALL be rejected when count!=0 and either (src_addr+count-1) or (dst_addr+count-1) exceeds LAST_ADDR.
REQ-021 That sum SHALL be computed 9 bits wide so that wrap-around counts as out of range.
REQ-022 On rejection: error=1 for the next cycle, the FSM stays in IDLE, and bus_req is never raised.
REQ-023 A start with count=0 SHALL go IDLE->FIN with no bus request, giving done one cycle after start.
REQ-024 A valid start with count>0 SHALL go IDLE->REQ; bus_req=1 in REQ, RD and WR.
REQ-025 REQ SHALL go to RD on the first edge where bus_grant=1.
REQ-026 RD SHALL drive mem_index={1,sp} and mem_wr=0, and latch mem_rdata into a 32-bit data register at the end of the cycle.
REQ-027 RD SHALL go to WR if bus_grant=1; otherwise it goes to REQ, the read is discarded, and no pointers advance.
REQ-028 WR SHALL drive mem_index={1,dp}, mem_wr=1 and mem_wdata=the data register.
REQ-029 The write in WR SHALL always complete, even if bus_grant drops during that cycle.
REQ-030 At the end of WR: sp+=1, dp+=1, cnt-=1.
REQ-031 From WR, the next state SHALL be FIN if cnt was 1, else RD if bus_grant=1, else REQ.
REQ-032 Latency SHALL be 2 cycles per word with continuous grant.
REQ-033 FIN SHALL give done=1 and bus_req=0 for one cycle, then go to IDLE.
REQ-034 busy SHALL be 1 in REQ, RD, WR and FIN.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 When not in RD or WR: mem_index=9'h000 (CS=0), mem_wr=0, mem_wdata=32'h0.
REQ-037 Overlapping source and destination ranges SHALL be copied in ascending address order, with no overlap correction.

Reset
REQ-038 When reset=1, the block SHALL immediately, without waiting for clk, set state=IDLE, bus_req=0, mem_index=0, mem_wr=0, mem_wdata=0, busy=0, done=0, error=0, and sp, dp, cnt and the data register to 0.
REQ-039 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; words already written stay written.
REQ-040 After reset deasserts, the first start SHALL be accepted on the next clk edge.

Verification
REQ-041 The bench SHALL cover: src=0, dst=100, count=3, grant held high -> bus_req one cycle after start, then 6 cycles alternating read and write; mem[100..102] = 1, 2, 3; done pulses once; the total is 8 cycles from start to done.
REQ-042 The bench SHALL cover: src=10, dst=150, count=2, grant dropped during the first RD -> FSM returns to REQ, the read is repeated after re-grant, and mem[150..151] = 11, 12.
REQ-043 The bench SHALL cover: src=0, dst=189, count=3 -> error pulses once, bus_req stays 0, and mem[189..190] are unchanged.
REQ-044 The bench SHALL cover: src=250, dst=0, count=10 -> error is raised because of the 9-bit wrap rule, and no memory access occurs.
REQ-045 The bench SHALL cover: count=0 -> done one cycle after start, with no bus_req and no CS.
REQ-046 The bench SHALL cover: reset asserted in the WR cycle of word 2 of a 5-word copy -> all outputs are 0 at once, no done, only the first words are written, and a new start is then accepted normally.
